lap_stop_watch: RTL and testbench
=================================

// Module: lap_stop_watch
// PURPOSE
//  Parametrised BCD stopwatch/timer for the 7-segment board display: DIGITS-wide BCD counter,
//  up or down mode, preset load, single-step, lap (display freeze) and countdown-done flag.
//  Everything runs on the single system clock: count and scan rates come from internal tick
//  enables, not divided clocks. Sits between debounced buttons/switches and the D1 display.
// PARAMETERS
//  TICK_DIV   100000  clk cycles per count tick (100 MHz -> 1 kHz count rate); >=2
//  SCAN_DIV   100000  clk cycles per display digit advance; >=2
//  DIGITS     4       BCD digits counted and displayed; 2..8
//  DP_POS     3       digit index whose decimal point is lit; 0..DIGITS-1
// PORTS
//  clk      in   1          system clock
//  rst      in   1          synchronous, active-high reset
//  btn      in   4          debounced levels: [0]start [1]stop [2]step [3]lap
//  mode     in   1          0 = count up, 1 = count down; latched on leaving IDLE
//  load     in   1          debounced level; rising edge loads preset (IDLE/DONE only)
//  preset   in   4*DIGITS   BCD preset, digit 0 in [3:0]
//  count    out  4*DIGITS   live BCD count
//  running  out  1          1 in RUN or STEP
//  done     out  1          1 in DONE
//  wrap     out  1          one-clk pulse when up-count wraps all-9s -> 0
//  D1_SEG   out  8          active-low {dp,g,f,e,d,c,b,a}
//  D1_AN    out  DIGITS     active-low one-hot digit enable
// BEHAVIOUR
//  - Reset (sync, highest priority): state IDLE, count=0, lap_reg=0, lap_hold=0, mode_q=0,
//    done=0, running=0, wrap=0, tick/scan dividers=0, scan idx=0 -> D1_AN=~1, D1_SEG shows '0'.
//  - Inputs btn/load registered once; actions fire on rising edge (one clk after the edge seen).
//  - tick: 1-clk pulse when tick divider = TICK_DIV-1 (divider wraps to 0); free-running.
//  - FSM (evaluated every clk; priority where several edges coincide: stop > lap > start > step):
//    IDLE : start -> RUN; step -> STEP; load -> count<=preset; mode_q<=mode on entering RUN/STEP.
//    RUN  : stop -> IDLE; lap toggles lap_hold (0->1 copies count to lap_reg); count moves on tick.
//    STEP : next tick applies exactly one count, then -> IDLE; stop before tick -> IDLE, no count.
//    DONE : count held at 0; load -> count<=preset, -> IDLE; start -> IDLE; others ignored.
//    Leaving RUN to IDLE clears lap_hold. btn[3] outside RUN ignored; load outside IDLE/DONE ignored.
//  - Up count on tick: digit0+1; digit k increments when all lower digits are 9; a digit at 9
//    that increments becomes 0. All-9s -> all-0, wrap pulses high same clk as the count update.
//  - Down count on tick: mirror borrow (0 -> 9). If count==0 at a tick in RUN/STEP: no change,
//    state -> DONE. Count never wraps down.
//  - Digits of preset above 9 load as-is; display shows blank (D1_SEG=8'hFF) for non-BCD digit;
//    counting treats a non-BCD digit as 9 (normalises on next carry/borrow).
//  - Display: scan idx advances 0..DIGITS-1 then 0 on scan pulse; D1_AN = ~(1<<idx);
//    value = lap_hold ? lap_reg : count; D1_SEG[7]=0 only when idx==DP_POS. Outputs registered,
//    update one clk after idx changes.
// TESTING (TICK_DIV=4, SCAN_DIV=2, DIGITS=4, DP_POS=3)
//  - rst 3 clks, hold 20 clks -> count=0000, D1_AN cycles 1110,1101,1011,0111, D1_SEG
//    0xC0,0xC0,0xC0,0x40, done=0.
//  - start pulse, run 40 ticks -> count=0040, running=1; stop -> count frozen at 0040 for 20 ticks.
//  - load preset 9998, start (up) -> after 2 ticks count=0000, wrap one clk high at 9999->0000.
//  - mode=1, load 0003, start -> 0002,0001,0000 then next tick done=1, count stays 0000;
//    start -> IDLE, done=0.
//  - RUN at 0012, lap -> display shows 0012 while count reaches 0020; lap again -> live 0020.
//  - step pulse in IDLE at 0005 -> exactly 0006 after next tick, back to IDLE; rst mid-RUN
//    at 0123 -> count=0000 next clk, state IDLE.

Source files
------------

// File: rtl/lap_stop_watch.sv
// BCD stopwatch/timer with up/down count, preset load, single-step, lap freeze and
// countdown-done flag, driving a multiplexed active-low 7-segment display.
module lap_stop_watch #(
  parameter int TICK_DIV = 100000,
  parameter int SCAN_DIV = 100000,
  parameter int DIGITS   = 4,
  parameter int DP_POS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            btn,
  input  logic                  mode,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  wrap,
  output logic [7:0]            D1_SEG,
  output logic [DIGITS-1:0]     D1_AN
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_DONE} state_t;

  state_t              state, state_n;
  logic [3:0]          btn_q, btn_p;
  logic                load_q, load_p;
  logic                start_e, stop_e, step_e, lap_e, load_e;
  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [SW-1:0]       scan_cnt;
  logic                scan;
  logic [IW-1:0]       scan_idx;
  logic                mode_q;
  logic                lap_hold;
  logic [4*DIGITS-1:0] lap_reg;
  logic [4*DIGITS-1:0] cnt_up, cnt_dn, disp_val;
  logic                up_carry, cnt_zero, carry, borrow;
  logic [3:0]          dig, disp_digit;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 is blanked.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // NOTE: every clocked register uses <= so all flops sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q  <= '0;
      btn_p  <= '0;
      load_q <= 1'b0;
      load_p <= 1'b0;
    end else begin
      btn_q  <= btn;
      btn_p  <= btn_q;
      load_q <= load;
      load_p <= load_q;
    end
  end

  assign start_e = btn_q[0] & ~btn_p[0];
  assign stop_e  = btn_q[1] & ~btn_p[1];
  assign step_e  = btn_q[2] & ~btn_p[2];
  assign lap_e   = btn_q[3] & ~btn_p[3];
  assign load_e  = load_q & ~load_p;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));
  assign scan = (scan_cnt == SW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      scan_cnt <= '0;
      scan_idx <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      scan_cnt <= scan ? '0 : scan_cnt + 1'b1;
      if (scan)
        scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  // Ripple BCD increment/decrement; a non-BCD digit behaves as 9 when a carry or borrow reaches it.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    cnt_up   = count;
    cnt_dn   = count;
    cnt_zero = 1'b1;
    carry    = 1'b1;
    borrow   = 1'b1;
    dig      = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dig = count[4*k +: 4];
      if (dig != 4'd0) cnt_zero = 1'b0;
      if (carry) begin
        if (dig >= 4'd9) cnt_up[4*k +: 4] = 4'd0;
        else begin
          cnt_up[4*k +: 4] = dig + 4'd1;
          carry            = 1'b0;
        end
      end
      if (borrow) begin
        if (dig == 4'd0) cnt_dn[4*k +: 4] = 4'd9;
        else begin
          cnt_dn[4*k +: 4] = (dig > 4'd9) ? 4'd8 : dig - 4'd1;
          borrow           = 1'b0;
        end
      end
    end
    up_carry = carry;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        // A coincident stop outranks start/step and keeps the watch idle.
        if (!stop_e) begin
          if (start_e)     state_n = S_RUN;
          else if (step_e) state_n = S_STEP;
        end
      end
      S_RUN: begin
        if (stop_e)                            state_n = S_IDLE;
        else if (tick && mode_q && cnt_zero)   state_n = S_DONE;
      end
      S_STEP: begin
        if (stop_e)    state_n = S_IDLE;
        else if (tick) state_n = (mode_q && cnt_zero) ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (load_e || start_e) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    running = (state == S_RUN) || (state == S_STEP);
    done    = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      lap_reg  <= '0;
      lap_hold <= 1'b0;
      mode_q   <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (state == S_IDLE && state_n != S_IDLE)
        mode_q <= mode;
      case (state)
        S_IDLE: begin
          if (load_e) count <= preset;
        end
        S_RUN: begin
          if (stop_e) lap_hold <= 1'b0;
          else begin
            if (lap_e) begin
              lap_hold <= ~lap_hold;
              if (!lap_hold) lap_reg <= count;
            end
            if (tick) begin
              if (!mode_q) begin
                count <= cnt_up;
                wrap  <= up_carry;
              end else if (!cnt_zero) count <= cnt_dn;
            end
          end
        end
        S_STEP: begin
          if (!stop_e && tick) begin
            if (!mode_q) begin
              count <= cnt_up;
              wrap  <= up_carry;
            end else if (!cnt_zero) count <= cnt_dn;
          end
        end
        S_DONE: begin
          if (load_e) count <= preset;
          // A lap freeze carried into DONE must not survive the return to IDLE.
          if (load_e || start_e) lap_hold <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign disp_val   = lap_hold ? lap_reg : count;
  assign disp_digit = disp_val[4*scan_idx +: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      D1_AN  <= ~DIGITS'(1);
      D1_SEG <= {(DP_POS != 0), 7'h40};
    end else begin
      D1_AN  <= ~(DIGITS'(1) << scan_idx);
      D1_SEG <= {(scan_idx != IW'(DP_POS)), seg7(disp_digit)};
    end
  end

endmodule

// File: tb/tb_lap_stop_watch.sv
// Directed bench for lap_stop_watch: expected values queued as stimulus is applied and
// popped when the DUT output is observed.
module tb_lap_stop_watch;

  localparam int TD = 4;
  localparam int SD = 2;
  localparam int ND = 4;
  localparam int DP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    btn;
  logic          mode, load;
  logic [15:0]   preset;
  logic [15:0]   count;
  logic          running, done, wrap;
  logic [7:0]    D1_SEG;
  logic [3:0]    D1_AN;

  always #5 clk = ~clk;

  lap_stop_watch #(.TICK_DIV(TD), .SCAN_DIV(SD), .DIGITS(ND), .DP_POS(DP)) dut (
    .clk(clk), .rst(rst), .btn(btn), .mode(mode), .load(load), .preset(preset),
    .count(count), .running(running), .done(done), .wrap(wrap),
    .D1_SEG(D1_SEG), .D1_AN(D1_AN)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [6:0] seg_model(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [15:0] bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic void push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb_q.push_back(x);
  endfunction

  task automatic check_pop(input logic [31:0] act);
    exp_t e;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $error("FAIL sb_empty observed=%0h", act);
    end else begin
      e = sb_q.pop_front();
      assert (act === e.exp) else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, act, e.exp);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] e);
    push(tag, e);
    check_pop(act);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_btn(input int b);
    btn[b] = 1'b1;
    @(negedge clk);
    btn[b] = 1'b0;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    preset = v;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    clks(3);
  endtask

  // Queue the next count value, wait (bounded) for the count to move, then compare.
  task automatic step_expect(input string tag, input logic [15:0] v);
    logic [15:0] old;
    bit          ok;
    old = count;
    ok  = 1'b0;
    push(tag, {16'h0, v});
    for (int i = 0; i < 3 * TD + 4; i++) begin
      @(negedge clk);
      if (count !== old) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) check_pop({16'h0, count});
    else begin
      void'(sb_q.pop_front());
      tests++;
      fails++;
      $error("FAIL %s timeout observed=%0h expected=%0h", tag, count, v);
    end
  endtask

  task automatic wait_value(input string tag, input logic [15:0] v, input int budget);
    push(tag, {16'h0, v});
    for (int i = 0; i < budget; i++) begin
      if (count === v) break;
      @(negedge clk);
    end
    check_pop({16'h0, count});
  endtask

  task automatic wait_an(input string tag, input logic [3:0] v);
    logic [3:0] old;
    old = D1_AN;
    push(tag, {28'h0, v});
    for (int i = 0; i < 2 * SD + 2; i++) begin
      @(negedge clk);
      if (D1_AN !== old) break;
    end
    check_pop({28'h0, D1_AN});
  endtask

  // Every sample: anode must be one-hot low and the segments must match the digit it selects.
  task automatic check_display(input string tag, input logic [15:0] v,
                               input logic [3:0] mask, input int n);
    int         idx;
    logic [7:0] e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      idx = -1;
      for (int k = 0; k < ND; k++)
        if (D1_AN === ~(4'b0001 << k)) idx = k;
      check({tag, "_an"}, {31'h0, idx >= 0}, 32'd1);
      if (idx >= 0 && mask[idx]) begin
        e = {1'(idx != DP), seg_model(v[4*idx +: 4])};
        check({tag, "_seg"}, {24'h0, D1_SEG}, {24'h0, e});
      end
    end
  endtask

  initial begin
    int          changes;
    logic [15:0] old;
    rst    = 1'b1;
    btn    = 4'b0;
    mode   = 1'b0;
    load   = 1'b0;
    preset = 16'h0;
    clks(3);
    rst = 1'b0;

    check("rst_count",   {16'h0, count}, 32'h0);
    check("rst_done",    {31'h0, done}, 32'h0);
    check("rst_running", {31'h0, running}, 32'h0);
    check("rst_wrap",    {31'h0, wrap}, 32'h0);
    check("rst_an",      {28'h0, D1_AN}, 32'hE);
    check("rst_seg",     {24'h0, D1_SEG}, 32'hC0);
    wait_an("scan_an1", 4'b1101);
    wait_an("scan_an2", 4'b1011);
    wait_an("scan_an3", 4'b0111);
    wait_an("scan_an0", 4'b1110);
    check_display("idle_disp", 16'h0000, 4'hF, 12);
    check("idle_count", {16'h0, count}, 32'h0);
    check("idle_done",  {31'h0, done}, 32'h0);

    pulse_btn(0);
    for (int i = 1; i <= 40; i++) step_expect($sformatf("run_%0d", i), bcd(i));
    check("run_running", {31'h0, running}, 32'd1);
    pulse_btn(1);
    changes = 0;
    old     = count;
    repeat (20 * TD) begin
      @(negedge clk);
      if (count !== old) changes++;
    end
    check("stop_changes", changes, 0);
    check("stop_count",   {16'h0, count}, 32'h0040);
    check("stop_running", {31'h0, running}, 32'h0);

    pulse_load(16'h9998);
    check("load_9998", {16'h0, count}, 32'h9998);
    pulse_btn(0);
    step_expect("up_9999", 16'h9999);
    check("wrap_low_9999", {31'h0, wrap}, 32'h0);
    step_expect("up_wrap_0000", 16'h0000);
    check("wrap_pulse", {31'h0, wrap}, 32'd1);
    @(negedge clk);
    check("wrap_one_clk", {31'h0, wrap}, 32'h0);
    pulse_btn(1);
    clks(3);

    mode = 1'b1;
    pulse_load(16'h0003);
    pulse_btn(0);
    step_expect("dn_0002", 16'h0002);
    step_expect("dn_0001", 16'h0001);
    step_expect("dn_0000", 16'h0000);
    for (int i = 0; i < 3 * TD + 4; i++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    check("cd_done",    {31'h0, done}, 32'd1);
    check("cd_running", {31'h0, running}, 32'h0);
    clks(3 * TD);
    check("cd_hold_count", {16'h0, count}, 32'h0);
    check("cd_hold_done",  {31'h0, done}, 32'd1);
    pulse_btn(0);
    clks(2);
    check("done_exit", {31'h0, done}, 32'h0);
    check("done_exit_running", {31'h0, running}, 32'h0);
    mode = 1'b0;

    pulse_load(16'h0011);
    pulse_btn(0);
    step_expect("lap_run_0012", 16'h0012);
    pulse_btn(3);
    clks(2);
    check_display("lap_frozen", 16'h0012, 4'hF, 16);
    wait_value("lap_reach_0020", 16'h0020, 20 * TD);
    pulse_btn(3);
    clks(2);
    check_display("lap_live", 16'h0020, 4'b1110, 12);
    pulse_btn(1);
    clks(3);

    pulse_load(16'h0005);
    check("load_0005", {16'h0, count}, 32'h0005);
    pulse_btn(2);
    step_expect("step_0006", 16'h0006);
    clks(3 * TD);
    check("step_hold",    {16'h0, count}, 32'h0006);
    check("step_running", {31'h0, running}, 32'h0);

    pulse_load(16'h0120);
    pulse_btn(0);
    wait_value("run_0123", 16'h0123, 10 * TD);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_count",   {16'h0, count}, 32'h0);
    check("midrst_running", {31'h0, running}, 32'h0);
    rst = 1'b0;
    clks(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
